// File: rtl/system_controller_pkg.sv
// Shared definitions for the register-file arbiter: FSM state encoding and
// the requester index constants used for grant and response routing.
package system_controller_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_READ = 2'd2,
    RESPOND   = 2'd3
  } arb_state_t;

  // Requester 0 is the UART command path, requester 1 the config/boot loader.
  localparam logic REQ_UART = 1'b0;
  localparam logic REQ_CFG  = 1'b1;

endpackage

// File: rtl/register_file_arbiter_if.sv
// Bundle of the two requester channels and the register-file port.
// The arbiter uses the slave view; requesters and the register file
// together form the master side.
interface register_file_arbiter_if #(
  parameter int DATA_WIDTH          = 8,
  parameter int REGISTER_FILE_DEPTH = 16
);

  localparam int AW = $clog2(REGISTER_FILE_DEPTH);

  logic                  req_0;
  logic                  req_1;
  logic                  write_enable_0;
  logic                  write_enable_1;
  logic [AW-1:0]         address_0;
  logic [AW-1:0]         address_1;
  logic [DATA_WIDTH-1:0] write_data_0;
  logic [DATA_WIDTH-1:0] write_data_1;
  logic                  grant_0;
  logic                  grant_1;
  logic                  read_data_valid_0;
  logic                  read_data_valid_1;
  logic [DATA_WIDTH-1:0] read_data_0;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic                  read_error_0;
  logic                  read_error_1;
  logic [AW-1:0]         register_file_address;
  logic                  register_file_write_enable;
  logic [DATA_WIDTH-1:0] register_file_write_data;
  logic                  register_file_read_enable;
  logic                  register_file_read_data_valid;
  logic [DATA_WIDTH-1:0] register_file_read_data;

  modport master (
    output req_0, req_1, write_enable_0, write_enable_1,
           address_0, address_1, write_data_0, write_data_1,
           register_file_read_data_valid, register_file_read_data,
    input  grant_0, grant_1, read_data_valid_0, read_data_valid_1,
           read_data_0, read_data_1, read_error_0, read_error_1,
           register_file_address, register_file_write_enable,
           register_file_write_data, register_file_read_enable
  );

  modport slave (
    input  req_0, req_1, write_enable_0, write_enable_1,
           address_0, address_1, write_data_0, write_data_1,
           register_file_read_data_valid, register_file_read_data,
    output grant_0, grant_1, read_data_valid_0, read_data_valid_1,
           read_data_0, read_data_1, read_error_0, read_error_1,
           register_file_address, register_file_write_enable,
           register_file_write_data, register_file_read_enable
  );

endinterface

// File: rtl/round_robin_select_2.sv
// Two-way round-robin chooser. Purely combinational: the caller owns the
// last_grant history and decides when a selection is actually taken.
module round_robin_select_2
  import system_controller_pkg::*;
(
  input  logic req_0,
  input  logic req_1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_index
);

  // A lone requester always wins; on contention the one not served last wins.
  always_comb begin
    grant_valid = req_0 | req_1;
    grant_index = REQ_UART;
    if (req_0 && req_1) begin
      grant_index = ~last_grant;
    end else if (req_1) begin
      grant_index = REQ_CFG;
    end
  end

endmodule

// File: rtl/register_file_arbiter.sv
// Shares the single register-file port between the UART command path and
// the config/boot loader. One access is in flight at a time; reads are
// tracked until data (or a timeout) returns and routed to their issuer.
module register_file_arbiter
  import system_controller_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int REGISTER_FILE_DEPTH = 16,
  parameter int READ_TIMEOUT        = 16
) (
  input  logic clk,
  input  logic reset,
  register_file_arbiter_if.slave bus
);

  localparam int AW = $clog2(REGISTER_FILE_DEPTH);
  localparam int CW = $clog2(READ_TIMEOUT);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(READ_TIMEOUT - 1);

  arb_state_t            state;
  logic                  last_grant;
  logic                  sel;
  logic                  lat_we;
  logic [CW-1:0]         timeout_count;

  logic                  grant_valid;
  logic                  grant_index;
  logic                  accept;
  logic                  sel_we;
  logic [AW-1:0]         sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  read_done;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_error;

  round_robin_select_2 u_select (
    .req_0       (bus.req_0),
    .req_1       (bus.req_1),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_index (grant_index)
  );

  // Grants are Mealy outputs: visible in the same IDLE cycle the request is seen,
  // and forced low while reset is held.
  always_comb begin
    accept      = reset && (state == IDLE) && grant_valid;
    bus.grant_0 = accept && (grant_index == REQ_UART);
    bus.grant_1 = accept && (grant_index == REQ_CFG);
  end

  // Mux the winning requester's command and form the read-completion result.
  always_comb begin
    sel_we     = (grant_index == REQ_CFG) ? bus.write_enable_1 : bus.write_enable_0;
    sel_addr   = (grant_index == REQ_CFG) ? bus.address_1      : bus.address_0;
    sel_wdata  = (grant_index == REQ_CFG) ? bus.write_data_1   : bus.write_data_0;
    read_done  = bus.register_file_read_data_valid || (timeout_count == TIMEOUT_LAST);
    resp_data  = bus.register_file_read_data_valid ? bus.register_file_read_data : '0;
    resp_error = !bus.register_file_read_data_valid;
  end

  // Main sequencer. The register-file outputs are loaded on the accepting edge,
  // so they double as the latched command during ISSUE; all strobes and
  // response flags default back to zero every cycle so they stay single pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                          <= IDLE;
      last_grant                     <= REQ_CFG;
      sel                            <= REQ_UART;
      lat_we                         <= 1'b0;
      timeout_count                  <= '0;
      bus.register_file_address      <= '0;
      bus.register_file_write_enable <= 1'b0;
      bus.register_file_write_data   <= '0;
      bus.register_file_read_enable  <= 1'b0;
      bus.read_data_valid_0          <= 1'b0;
      bus.read_data_valid_1          <= 1'b0;
      bus.read_data_0                <= '0;
      bus.read_data_1                <= '0;
      bus.read_error_0               <= 1'b0;
      bus.read_error_1               <= 1'b0;
    end else begin
      bus.register_file_address      <= '0;
      bus.register_file_write_enable <= 1'b0;
      bus.register_file_write_data   <= '0;
      bus.register_file_read_enable  <= 1'b0;
      bus.read_data_valid_0          <= 1'b0;
      bus.read_data_valid_1          <= 1'b0;
      bus.read_error_0               <= 1'b0;
      bus.read_error_1               <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_valid) begin
            sel                            <= grant_index;
            last_grant                     <= grant_index;
            lat_we                         <= sel_we;
            bus.register_file_address      <= sel_addr;
            bus.register_file_write_data   <= sel_wdata;
            bus.register_file_write_enable <= sel_we;
            bus.register_file_read_enable  <= !sel_we;
            state                          <= ISSUE;
          end
        end

        ISSUE: begin
          if (lat_we) begin
            state <= IDLE;
          end else begin
            timeout_count <= '0;
            state         <= WAIT_READ;
          end
        end

        WAIT_READ: begin
          timeout_count <= timeout_count + CW'(1);
          if (read_done) begin
            if (sel == REQ_CFG) begin
              bus.read_data_valid_1 <= 1'b1;
              bus.read_data_1       <= resp_data;
              bus.read_error_1      <= resp_error;
            end else begin
              bus.read_data_valid_0 <= 1'b1;
              bus.read_data_0       <= resp_data;
              bus.read_error_0      <= resp_error;
            end
            state <= RESPOND;
          end
        end

        RESPOND: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_file_arbiter.sv
// Self-checking bench for register_file_arbiter: directed scenarios with
// literal expectations, then randomized traffic, all checked every cycle
// against a timestamp-based transaction model.
module tb_register_file_arbiter;

  localparam int DATA_WIDTH          = 8;
  localparam int REGISTER_FILE_DEPTH = 16;
  localparam int AW                  = 4;
  localparam int READ_TIMEOUT        = 16;
  localparam int NEVER               = 2147483647;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  register_file_arbiter_if #(
    .DATA_WIDTH          (DATA_WIDTH),
    .REGISTER_FILE_DEPTH (REGISTER_FILE_DEPTH)
  ) bus ();

  register_file_arbiter #(
    .DATA_WIDTH          (DATA_WIDTH),
    .REGISTER_FILE_DEPTH (REGISTER_FILE_DEPTH),
    .READ_TIMEOUT        (READ_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Stimulus for the current cycle
  logic                  s_req   [2];
  logic                  s_we    [2];
  logic [AW-1:0]         s_addr  [2];
  logic [DATA_WIDTH-1:0] s_wdata [2];
  logic                  s_rf_valid;
  logic [DATA_WIDTH-1:0] s_rf_data;

  // Transaction model: everything is expressed as cycle timestamps
  int                    cyc;
  int                    free_at;
  int                    last_winner;
  int                    model_win;
  int                    issue_cyc;
  logic                  issue_we;
  logic [AW-1:0]         issue_addr;
  logic [DATA_WIDTH-1:0] issue_wdata;
  bit                    read_open;
  int                    win_start;
  int                    rd_req;
  int                    resp_cyc;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] exp_rd [2];

  // Observed DUT outputs of the current cycle
  logic [1:0]  obs_g;
  logic [13:0] obs_rf;
  logic [19:0] obs_resp;

  int checks_total;
  int checks_passed;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  function automatic logic [63:0] allOutputs();
    return 64'({bus.grant_1, bus.grant_0, bus.read_data_valid_1, bus.read_data_valid_0,
                bus.read_error_1, bus.read_error_0, bus.read_data_1, bus.read_data_0,
                bus.register_file_address, bus.register_file_write_enable,
                bus.register_file_write_data, bus.register_file_read_enable});
  endfunction

  task automatic applyStimulus();
    bus.req_0                         = s_req[0];
    bus.req_1                         = s_req[1];
    bus.write_enable_0                = s_we[0];
    bus.write_enable_1                = s_we[1];
    bus.address_0                     = s_addr[0];
    bus.address_1                     = s_addr[1];
    bus.write_data_0                  = s_wdata[0];
    bus.write_data_1                  = s_wdata[1];
    bus.register_file_read_data_valid = s_rf_valid;
    bus.register_file_read_data       = s_rf_data;
  endtask

  task automatic modelReset(input int start);
    free_at     = start;
    last_winner = 1;
    model_win   = -1;
    issue_cyc   = -1;
    resp_cyc    = -1;
    read_open   = 0;
    rd_req      = 0;
    exp_rd[0]   = '0;
    exp_rd[1]   = '0;
  endtask

  // Derive this cycle's expected outputs from the model and compare.
  task automatic checkOutput();
    logic [1:0]            exp_g;
    logic                  exp_we;
    logic                  exp_re;
    logic [AW-1:0]         exp_addr;
    logic [DATA_WIDTH-1:0] exp_wd;
    logic [1:0]            exp_rdv;
    logic [1:0]            exp_err;
    exp_g     = 2'b00;
    model_win = -1;
    if (cyc >= free_at) begin
      if (s_req[0] && s_req[1]) model_win = 1 - last_winner;
      else if (s_req[0])        model_win = 0;
      else if (s_req[1])        model_win = 1;
    end
    if (model_win == 0) exp_g = 2'b01;
    if (model_win == 1) exp_g = 2'b10;
    exp_we   = (cyc == issue_cyc) &&  issue_we;
    exp_re   = (cyc == issue_cyc) && !issue_we;
    exp_addr = (cyc == issue_cyc) ? issue_addr  : '0;
    exp_wd   = (cyc == issue_cyc) ? issue_wdata : '0;
    exp_rdv  = 2'b00;
    exp_err  = 2'b00;
    if (cyc == resp_cyc) begin
      exp_rdv[rd_req] = 1'b1;
      exp_err[rd_req] = resp_err;
      exp_rd[rd_req]  = resp_data;
    end
    obs_g    = {bus.grant_1, bus.grant_0};
    obs_rf   = {bus.register_file_write_enable, bus.register_file_read_enable,
                bus.register_file_address, bus.register_file_write_data};
    obs_resp = {bus.read_data_valid_1, bus.read_data_valid_0, bus.read_error_1,
                bus.read_error_0, bus.read_data_1, bus.read_data_0};
    checkVal("grant", 64'(obs_g), 64'(exp_g));
    checkVal("rf_port", 64'(obs_rf), 64'({exp_we, exp_re, exp_addr, exp_wd}));
    checkVal("response", 64'(obs_resp),
             64'({exp_rdv[1], exp_rdv[0], exp_err[1], exp_err[0], exp_rd[1], exp_rd[0]}));
  endtask

  // Move the model forward using this cycle's grant and register-file inputs.
  task automatic modelAdvance();
    if (model_win >= 0) begin
      last_winner = model_win;
      issue_cyc   = cyc + 1;
      issue_we    = s_we[model_win];
      issue_addr  = s_addr[model_win];
      issue_wdata = s_wdata[model_win];
      if (issue_we) begin
        free_at = cyc + 2;
      end else begin
        read_open = 1;
        win_start = cyc + 2;
        rd_req    = model_win;
        free_at   = NEVER;
      end
    end
    if (read_open && cyc >= win_start) begin
      if (s_rf_valid) begin
        resp_cyc  = cyc + 1;
        resp_data = s_rf_data;
        resp_err  = 1'b0;
        read_open = 0;
        free_at   = cyc + 2;
      end else if (cyc == win_start + READ_TIMEOUT - 1) begin
        resp_cyc  = cyc + 1;
        resp_data = '0;
        resp_err  = 1'b1;
        read_open = 0;
        free_at   = cyc + 2;
      end
    end
  endtask

  task automatic runCycle();
    @(posedge clk);
    #1;
    applyStimulus();
    cyc++;
    @(negedge clk);
    checkOutput();
    modelAdvance();
  endtask

  task automatic newRequest(input int r);
    s_req[r]   = 1'b1;
    s_we[r]    = 1'($urandom_range(0, 1));
    s_addr[r]  = AW'($urandom);
    s_wdata[r] = DATA_WIDTH'($urandom);
  endtask

  task automatic randomUpdate();
    for (int r = 0; r < 2; r++) begin
      if (model_win == r) begin
        if ($urandom_range(0, 1) == 0) newRequest(r);
        else s_req[r] = 1'b0;
      end else if (s_req[r]) begin
        if ($urandom_range(0, 15) == 0) s_req[r] = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        newRequest(r);
      end
    end
    s_rf_valid = ($urandom_range(0, 11) == 0);
    s_rf_data  = DATA_WIDTH'($urandom);
  endtask

  task automatic setReq(input int r, input logic req, input logic we,
                        input logic [AW-1:0] addr, input logic [DATA_WIDTH-1:0] wdata);
    s_req[r]   = req;
    s_we[r]    = we;
    s_addr[r]  = addr;
    s_wdata[r] = wdata;
  endtask

  initial begin
    int pulses;
    logic [1:0] exp_g;
    checks_total  = 0;
    checks_passed = 0;
    cyc           = 0;
    for (int r = 0; r < 2; r++) setReq(r, 1'b0, 1'b0, '0, '0);
    s_rf_valid = 1'b0;
    s_rf_data  = '0;
    applyStimulus();
    modelReset(1);

    // Reset state
    repeat (3) @(negedge clk);
    checkVal("reset_state", allOutputs(), 64'd0);
    reset = 1'b1;
    modelReset(cyc + 1);

    // Single write
    setReq(0, 1'b1, 1'b1, 4'd3, 8'hA5);
    runCycle();
    checkVal("write_grant", 64'(obs_g), 64'(2'b01));
    s_req[0] = 1'b0;
    runCycle();
    checkVal("write_strobe", 64'(obs_rf), 64'({1'b1, 1'b0, 4'd3, 8'hA5}));
    runCycle();
    checkVal("write_strobe_single", 64'(obs_rf), 64'd0);

    // Read round trip, data two cycles after read_enable
    setReq(1, 1'b1, 1'b0, 4'd7, 8'h00);
    runCycle();
    checkVal("read_grant", 64'(obs_g), 64'(2'b10));
    s_req[1] = 1'b0;
    runCycle();
    checkVal("read_strobe", 64'(obs_rf), 64'({1'b0, 1'b1, 4'd7, 8'h00}));
    runCycle();
    s_rf_valid = 1'b1;
    s_rf_data  = 8'h3C;
    runCycle();
    s_rf_valid = 1'b0;
    runCycle();
    checkVal("read_response", 64'(obs_resp), 64'({4'b1000, 8'h3C, 8'h00}));
    runCycle();
    checkVal("read_data_held", 64'(obs_resp), 64'({4'b0000, 8'h3C, 8'h00}));

    // Contention: both write continuously, grants alternate every 2nd cycle
    setReq(0, 1'b1, 1'b1, 4'd1, 8'h11);
    setReq(1, 1'b1, 1'b1, 4'd2, 8'h22);
    for (int k = 0; k < 8; k++) begin
      runCycle();
      exp_g = (k % 2 != 0) ? 2'b00 : (((k / 2) % 2 != 0) ? 2'b10 : 2'b01);
      checkVal($sformatf("contention_%0d", k), 64'(obs_g), 64'(exp_g));
    end
    s_req[0] = 1'b0;
    s_req[1] = 1'b0;
    runCycle();

    // Timeout: no valid ever returns
    setReq(0, 1'b1, 1'b0, 4'd9, 8'h11);
    runCycle();
    s_req[0] = 1'b0;
    runCycle();
    repeat (READ_TIMEOUT) runCycle();
    runCycle();
    checkVal("timeout_response", 64'(obs_resp), 64'({4'b0101, 8'h3C, 8'h00}));

    // Valid arriving on the final timeout cycle wins
    setReq(1, 1'b1, 1'b0, 4'd2, 8'h00);
    runCycle();
    s_req[1] = 1'b0;
    runCycle();
    repeat (READ_TIMEOUT - 1) runCycle();
    s_rf_valid = 1'b1;
    s_rf_data  = 8'h5A;
    runCycle();
    s_rf_valid = 1'b0;
    runCycle();
    checkVal("last_cycle_valid", 64'(obs_resp), 64'({4'b1000, 8'h5A, 8'h00}));

    // Stray valid in IDLE
    s_rf_valid = 1'b1;
    s_rf_data  = 8'hEE;
    repeat (4) begin
      runCycle();
      checkVal("stray_valid", 64'(obs_resp[19:18]), 64'd0);
    end
    s_rf_valid = 1'b0;

    // Reset during WAIT_READ
    setReq(0, 1'b1, 1'b0, 4'd5, 8'h00);
    runCycle();
    s_req[0] = 1'b0;
    runCycle();
    runCycle();
    runCycle();
    @(posedge clk);
    #2;
    reset      = 1'b0;
    s_rf_valid = 1'b1;
    s_rf_data  = 8'h77;
    applyStimulus();
    #1;
    checkVal("reset_async", allOutputs(), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    modelReset(cyc + 1);
    pulses = 0;
    repeat (4) begin
      runCycle();
      if (bus.read_data_valid_0) pulses++;
    end
    checkVal("no_resp_after_reset", 64'(pulses), 64'd0);
    s_rf_valid = 1'b0;
    setReq(0, 1'b1, 1'b1, 4'd4, 8'h44);
    setReq(1, 1'b1, 1'b1, 4'd6, 8'h66);
    runCycle();
    checkVal("first_grant_after_reset", 64'(obs_g), 64'(2'b01));
    s_req[0] = 1'b0;
    s_req[1] = 1'b0;
    runCycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      randomUpdate();
      runCycle();
    end

    s_req[0]   = 1'b0;
    s_req[1]   = 1'b0;
    s_rf_valid = 1'b0;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
